// File: rtl/mem_line_ctrl.sv
// Memory-side line controller: fixed-latency READ_LINE / WRITE_LINE service over a beat bus,
// backed by an internal byte array. Tristate control is exported via cmd_oe / data_oe.
module mem_line_ctrl #(
    parameter int unsigned MEM_ADDR_SIZE     = 19,
    parameter int unsigned BUS_SIZE          = 16,
    parameter int unsigned CACHE_OFFSET_SIZE = 4,
    parameter int unsigned CACHE_LINE_SIZE   = 16,
    parameter int unsigned MEM_LATENCY       = 100
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] mem_address,
    input  logic [1:0]                                 cmd_in,
    output logic [1:0]                                 cmd_out,
    output logic                                       cmd_oe,
    input  logic [BUS_SIZE-1:0]                        data_in,
    output logic [BUS_SIZE-1:0]                        data_out,
    output logic                                       data_oe,
    output logic                                       busy,
    output logic                                       proto_err
);

    localparam int unsigned LAW   = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int unsigned BEATS = CACHE_LINE_SIZE * 8 / BUS_SIZE;
    localparam int unsigned BPB   = BUS_SIZE / 8;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CW    = $clog2(MEM_LATENCY);

    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_RESP  = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    typedef enum logic [2:0] {StIdle, StRecv, StWait, StSend, StResp} state_e;

    state_e                state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LAW-1:0]        addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [1:0]            cmd_out_q, cmd_out_d;
    logic                  cmd_oe_q, cmd_oe_d;
    logic [BUS_SIZE-1:0]   data_out_q, data_out_d;
    logic                  data_oe_q, data_oe_d;

    logic [7:0]               mem [2**MEM_ADDR_SIZE];
    logic [7:0]               lbuf [CACHE_LINE_SIZE];
    logic [MEM_ADDR_SIZE-1:0] line_base;
    logic [BUS_SIZE-1:0]      rd_beat;
    logic                     cap_en;
    logic [BW-1:0]            cap_beat;

    assign line_base = {addr_q, {CACHE_OFFSET_SIZE{1'b0}}};

    always_comb begin
        rd_beat = '0;
        for (int j = 0; j < int'(BPB); j++) begin
            rd_beat[j*8 +: 8] = mem[line_base + MEM_ADDR_SIZE'(int'(beat_q) * int'(BPB) + j)];
        end
    end

    // Beat 0 of a write arrives with the command itself, the rest while in RECV.
    always_comb begin
        cap_en   = 1'b0;
        cap_beat = beat_q;
        if (state_q == StIdle && cmd_in == CMD_WRITE) begin
            cap_en   = 1'b1;
            cap_beat = '0;
        end else if (state_q == StRecv) begin
            cap_en = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        err_d      = err_q;
        busy_d     = busy_q;
        cmd_out_d  = CMD_NOP;
        cmd_oe_d   = 1'b0;
        data_out_d = '0;
        data_oe_d  = 1'b0;

        if (state_q != StIdle && (cmd_in == CMD_READ || cmd_in == CMD_WRITE)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (cmd_in == CMD_READ || cmd_in == CMD_WRITE) begin
                    addr_d = mem_address;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (cmd_in == CMD_WRITE) begin
                        wr_d    = 1'b1;
                        beat_d  = BW'(1);
                        state_d = (BEATS == 1) ? StWait : StRecv;
                    end else begin
                        wr_d    = 1'b0;
                        beat_d  = '0;
                        state_d = StWait;
                    end
                end
            end
            StRecv: begin
                cnt_d  = cnt_q + CW'(1);
                beat_d = beat_q + BW'(1);
                if (beat_q == BW'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CW'(1);
                // cnt_q trails the cycle number by one, so this edge is cycle MEM_LATENCY-1.
                if (cnt_q == CW'(MEM_LATENCY - 2)) begin
                    beat_d  = '0;
                    state_d = wr_q ? StResp : StSend;
                end
            end
            StSend: begin
                cmd_out_d  = CMD_RESP;
                cmd_oe_d   = 1'b1;
                data_oe_d  = 1'b1;
                data_out_d = rd_beat;
                beat_d     = beat_q + BW'(1);
                if (beat_q == BW'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = StIdle;
                end
            end
            StResp: begin
                cmd_out_d = CMD_RESP;
                cmd_oe_d  = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            cmd_out_q  <= CMD_NOP;
            cmd_oe_q   <= 1'b0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            cmd_out_q  <= cmd_out_d;
            cmd_oe_q   <= cmd_oe_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
        end
    end

    // Storage is deliberately not reset; a reset mid-write leaves state_q idle so nothing commits.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            for (int j = 0; j < int'(BPB); j++) begin
                lbuf[CACHE_OFFSET_SIZE'(int'(cap_beat) * int'(BPB) + j)] <= data_in[j*8 +: 8];
            end
        end
        if (state_q == StResp) begin
            for (int i = 0; i < int'(CACHE_LINE_SIZE); i++) begin
                mem[line_base + MEM_ADDR_SIZE'(i)] <= lbuf[i];
            end
        end
    end

    assign cmd_out   = cmd_out_q;
    assign cmd_oe    = cmd_oe_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign busy      = busy_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed plus randomized bench for mem_line_ctrl against a byte-array reference model.
module tb_mem_line_ctrl;

    localparam int L     = 100;
    localparam int BEATS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] mem_address;
    logic [1:0]  cmd_in;
    logic [1:0]  cmd_out;
    logic        cmd_oe;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_oe;
    logic        busy;
    logic        proto_err;

    int vectors = 0;
    int errors  = 0;
    logic err_exp = 1'b0;
    logic [7:0] model [int];
    int written [$];

    mem_line_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .mem_address (mem_address),
        .cmd_in      (cmd_in),
        .cmd_out     (cmd_out),
        .cmd_oe      (cmd_oe),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic eoe, input logic [1:0] ecmd,
                              input logic edoe, input logic [15:0] edata, input logic ebusy,
                              input logic eerr);
        logic [21:0] got;
        logic [21:0] exp;
        got = {cmd_oe, cmd_out, data_oe, data_out, busy, proto_err};
        exp = {eoe, ecmd, edoe, edata, ebusy, eerr};
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed={oe,cmd,doe,data,busy,err}=%h expected=%h", tag, got, exp);
        end
    endtask

    // Beat k of a line is two consecutive bytes, low address in the low byte.
    function automatic logic [15:0] model_beat(input int addr, input int k);
        int b;
        b = addr * 16 + k * 2;
        return {model[b + 1], model[b]};
    endfunction

    task automatic do_read(input int addr, input int inj);
        cmd_in      = 2'd2;
        mem_address = 15'(addr);
        tick();
        cmd_in      = 2'd0;
        mem_address = 15'($urandom);
        expect_out("rd_c0", 0, 2'd0, 0, 16'h0, 1, err_exp);
        for (int n = 1; n < L; n++) begin
            if (n == inj) begin
                cmd_in      = 2'd2;
                mem_address = 15'(~addr);
            end
            tick();
            cmd_in = 2'd0;
            if (n == inj) err_exp = 1'b1;
            expect_out($sformatf("rd_wait_c%0d", n), 0, 2'd0, 0, 16'h0, 1, err_exp);
        end
        for (int k = 0; k < BEATS; k++) begin
            tick();
            expect_out($sformatf("rd_beat%0d_a%0h", k, addr), 1, 2'd1, 1,
                       model_beat(addr, k), 1, err_exp);
        end
    endtask

    task automatic do_write(input int addr, input logic [127:0] line);
        cmd_in      = 2'd3;
        mem_address = 15'(addr);
        data_in     = line[15:0];
        tick();
        cmd_in = 2'd0;
        expect_out("wr_c0", 0, 2'd0, 0, 16'h0, 1, err_exp);
        for (int n = 1; n < BEATS; n++) begin
            data_in = line[n*16 +: 16];
            tick();
            expect_out($sformatf("wr_recv_c%0d", n), 0, 2'd0, 0, 16'h0, 1, err_exp);
        end
        data_in = 16'($urandom);
        for (int n = BEATS; n < L; n++) begin
            tick();
            expect_out($sformatf("wr_wait_c%0d", n), 0, 2'd0, 0, 16'h0, 1, err_exp);
        end
        tick();
        expect_out("wr_resp", 1, 2'd1, 0, 16'h0, 1, err_exp);
        for (int i = 0; i < 16; i++) model[addr * 16 + i] = line[i*8 +: 8];
        written.push_back(addr);
    endtask

    initial begin
        logic [127:0] line;
        int a;

        reset = 1'b0; cmd_in = 2'd0; mem_address = '0; data_in = '0;
        tick(); tick();
        expect_out("reset_state", 0, 2'd0, 0, 16'h0, 0, 0);
        reset = 1'b1;
        tick();
        expect_out("idle_after_reset", 0, 2'd0, 0, 16'h0, 0, 0);

        // Line 0x5 = bytes 0x00..0x0F, then read it back.
        for (int i = 0; i < 16; i++) line[i*8 +: 8] = 8'(i);
        do_write(5, line);
        do_read(5, 0);
        tick();
        expect_out("rd5_end", 0, 2'd0, 0, 16'h0, 0, 0);

        // Top line, then a read issued the cycle after its last beat.
        for (int k = 0; k < BEATS; k++) line[k*16 +: 16] = {8'(8'hA0 + k), 8'(8'hA1 + k)};
        do_write(15'h7FFF, line);
        do_read(15'h7FFF, 0);
        do_read(5, 0);
        tick();
        expect_out("b2b_end", 0, 2'd0, 0, 16'h0, 0, 0);

        // RESPONSE while idle is harmless.
        cmd_in = 2'd1;
        for (int n = 0; n < 3; n++) begin
            tick();
            expect_out("resp_in_idle", 0, 2'd0, 0, 16'h0, 0, 0);
        end
        cmd_in = 2'd0;

        // Write aborted by reset at cycle 50 must not touch memory.
        line = {$urandom, $urandom, $urandom, $urandom};
        do_write(3, line);
        cmd_in = 2'd3; mem_address = 15'h3; data_in = 16'hDEAD;
        tick();
        cmd_in = 2'd0;
        for (int n = 1; n <= 50; n++) begin
            data_in = 16'($urandom);
            tick();
        end
        reset = 1'b0;
        #1;
        expect_out("wr_abort_rst", 0, 2'd0, 0, 16'h0, 0, 0);
        tick(); tick();
        expect_out("wr_abort_hold", 0, 2'd0, 0, 16'h0, 0, 0);
        reset = 1'b1;
        tick();
        do_read(3, 0);
        tick();
        expect_out("rd3_end", 0, 2'd0, 0, 16'h0, 0, 0);

        // Second READ_LINE at cycle 20: ignored, sticky error.
        do_read(5, 20);
        tick();
        expect_out("err_sticky_idle", 0, 2'd0, 0, 16'h0, 0, 1);
        do_read(15'h7FFF, 0);
        tick();
        reset = 1'b0;
        #1;
        err_exp = 1'b0;
        expect_out("err_cleared", 0, 2'd0, 0, 16'h0, 0, 0);
        reset = 1'b1;
        tick();

        // Reset mid-SEND kills the burst immediately.
        cmd_in = 2'd2; mem_address = 15'h5;
        tick();
        cmd_in = 2'd0;
        for (int n = 1; n < L + 3; n++) tick();
        expect_out("send_before_rst", 1, 2'd1, 1, model_beat(5, 2), 1, 0);
        reset = 1'b0;
        #1;
        expect_out("send_rst", 0, 2'd0, 0, 16'h0, 0, 0);
        tick();
        expect_out("send_rst_hold", 0, 2'd0, 0, 16'h0, 0, 0);
        reset = 1'b1;
        tick();

        // Random lines against the model.
        for (int r = 0; r < 6; r++) begin
            a = int'($urandom_range(0, 32767));
            line = {$urandom, $urandom, $urandom, $urandom};
            do_write(a, line);
            a = written[$urandom_range(0, written.size() - 1)];
            do_read(a, 0);
            tick();
            expect_out("rand_end", 0, 2'd0, 0, 16'h0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
